// File: rtl/fetch_unit_v3.sv
// fetch_unit_v3: holds the PC, fetches over a variable-latency req/ack port,
// presents the instruction and decode slices, and sequences the PC on retire.
module fetch_unit_v3 #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] imm_ext,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] instret
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [1:0]  FC_NONE     = 2'b00;
    localparam logic [1:0]  FC_MISALIGN = 2'b01;
    localparam logic [1:0]  FC_TIMEOUT  = 2'b10;
    localparam logic [31:0] WAIT_LIMIT  = 32'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] wait_q, wait_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_next;

    // Retire target; only consumed on a non-stalled EXEC edge.
    assign pc_next = pc_src ? (pc_q + imm_ext) : (pc_q + 32'd4);

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        instret_d    = instret_q;
        wait_d       = wait_q;
        fault_code_d = fault_code_q;
        valid_d      = valid_q;
        case (state_q)
            IDLE: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d      = FAULT;
                    fault_code_d = FC_MISALIGN;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                    state_d = EXEC;
                end else if ((wait_q + 32'd1) >= WAIT_LIMIT) begin
                    wait_d       = wait_q + 32'd1;
                    state_d      = FAULT;
                    fault_code_d = FC_TIMEOUT;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    // The faulting target is still committed so it stays observable on pc.
                    pc_d      = pc_next;
                    instret_d = instret_q + 32'd1;
                    valid_d   = 1'b0;
                    wait_d    = 32'd0;
                    if (pc_next[1:0] != 2'b00) begin
                        state_d      = FAULT;
                        fault_code_d = FC_MISALIGN;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= NOP_INSTR;
            instret_q    <= 32'd0;
            wait_q       <= 32'd0;
            fault_code_q <= FC_NONE;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            instret_q    <= instret_d;
            wait_q       <= wait_d;
            fault_code_q <= fault_code_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = valid_q ? ir_q : NOP_INSTR;
    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7_5    = instr[30];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fault       = (state_q == FAULT);
    assign fault_code  = fault_code_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit_v3.sv
// Testbench for fetch_unit_v3: transaction-level reference model of PC/instret
// driven by randomized memory latency, stalls and branch targets.
module tb_fetch_unit_v3;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          MAXW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] imm_ext = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] instret;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    fetch_unit_v3 dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .pc_src(pc_src), .imm_ext(imm_ext),
        .instr(instr), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .fault(fault), .fault_code(fault_code), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom; stall = 1'b0; pc_src = 1'b0;
        tick();
        tick();
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0 || fault_code !== 2'b00 ||
            pc !== 32'd0 || instret !== 32'd0 || instr !== NOP) begin
            errors++;
            $display("FAIL reset: req=%b valid=%b fault=%b code=%b pc=%h instret=%0d instr=%h, expected 0/0/0/00/0/0/%h",
                     imem_req, instr_valid, fault, fault_code, pc, instret, instr, NOP);
        end
        reset = 1'b0;
        m_pc = 32'd0;
        m_instret = 32'd0;
    endtask

    // One full instruction: fetch with 'delay' unacked cycles, 'nstall' stalled EXEC cycles, then retire.
    task automatic do_instr(input logic [31:0] word, input int delay, input int nstall,
                            input logic take, input logic [31:0] imm);
        for (int i = 0; i < 4 && imem_req !== 1'b1; i++) tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || instr !== NOP) begin
            errors++;
            $display("FAIL fetch_issue: req=%b addr=%h valid=%b instr=%h, expected req=1 addr=%h valid=0 instr=%h",
                     imem_req, imem_addr, instr_valid, instr, m_pc, NOP);
        end
        for (int d = 0; d < delay; d++) begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0 || fault !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait: req=%b addr=%h valid=%b fault=%b, expected req=1 addr=%h valid=0 fault=0",
                         imem_req, imem_addr, instr_valid, fault, m_pc);
            end
        end
        imem_ack = 1'b1; imem_rdata = word; stall = 1'($urandom); pc_src = 1'($urandom); imm_ext = $urandom;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== word || opcode !== word[6:0] || funct3 !== word[14:12] ||
            funct7_5 !== word[30] || pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || imem_req !== 1'b0 ||
            instret !== m_instret) begin
            errors++;
            $display("FAIL exec_present: valid=%b instr=%h op=%h f3=%h f7=%b pc=%h pc4=%h req=%b instret=%0d, expected instr=%h pc=%h instret=%0d",
                     instr_valid, instr, opcode, funct3, funct7_5, pc, pc_plus4, imem_req, instret, word, m_pc, m_instret);
        end
        for (int s = 0; s < nstall; s++) begin
            stall = 1'b1; pc_src = 1'($urandom); imm_ext = $urandom; imem_ack = 1'($urandom); imem_rdata = $urandom;
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== word || pc !== m_pc || instret !== m_instret ||
                imem_req !== 1'b0 || fault !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b instr=%h pc=%h instret=%0d req=%b fault=%b, expected 1/%h/%h/%0d/0/0",
                         instr_valid, instr, pc, instret, imem_req, fault, word, m_pc, m_instret);
            end
        end
        stall = 1'b0; pc_src = take; imm_ext = imm; imem_ack = 1'b0;
        tick();
        m_pc = take ? (m_pc + imm) : (m_pc + 32'd4);
        m_instret = m_instret + 32'd1;
        pc_src = 1'($urandom); imm_ext = $urandom;
        checks++;
        if (pc !== m_pc || instret !== m_instret || instr_valid !== 1'b0 || instr !== NOP) begin
            errors++;
            $display("FAIL retire: pc=%h instret=%0d valid=%b instr=%h, expected pc=%h instret=%0d valid=0 instr=%h",
                     pc, instret, instr_valid, instr, m_pc, m_instret, NOP);
        end
        checks++;
        if (m_pc[1:0] != 2'b00) begin
            if (fault !== 1'b1 || fault_code !== 2'b01 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL misaligned: fault=%b code=%b req=%b, expected 1/01/0", fault, fault_code, imem_req);
            end
        end else if (imem_req !== 1'b1 || imem_addr !== m_pc || fault !== 1'b0) begin
            errors++;
            $display("FAIL next_fetch: req=%b addr=%h fault=%b, expected 1/%h/0", imem_req, imem_addr, fault, m_pc);
        end
    endtask

    task automatic test_cold_start();
        time t0;
        test_reset();
        t0 = $time;
        do_instr(32'h0050_0093, 0, 0, 1'b0, 32'd0);
        do_instr(32'h0010_0113, 0, 0, 1'b0, 32'd0);
        checks++;
        if (instret !== 32'd2 || ($time - t0) != 50 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL cold_start: instret=%0d cycles=%0d addr=%h, expected 2 instrs in 5 edges from IDLE, addr=8",
                     instret, ($time - t0) / 10, imem_addr);
        end
    endtask

    task automatic test_delay();
        do_instr($urandom, 3, 0, 1'b0, 32'd0);
        do_instr($urandom, 7, 1, 1'b0, 32'd0);
    endtask

    task automatic test_branch();
        test_reset();
        do_instr($urandom, 0, 0, 1'b1, 32'h0000_0100);
        do_instr($urandom, 1, 0, 1'b1, 32'hFFFF_FFF0);
        checks++;
        if (imem_addr !== 32'h0000_00F0) begin
            errors++;
            $display("FAIL branch_back: addr=%h, expected 000000f0", imem_addr);
        end
        do_instr($urandom, 0, 0, 1'b1, 32'h0000_0010);
        do_instr($urandom, 0, 0, 1'b0, 32'hDEAD_BEEF);
        checks++;
        if (imem_addr !== 32'h0000_0104) begin
            errors++;
            $display("FAIL no_branch: addr=%h, expected 00000104", imem_addr);
        end
        do_instr($urandom, 0, 0, 1'b1, 32'hFFFF_FFFC - m_pc);
        do_instr($urandom, 2, 0, 1'b0, 32'd0);
        checks++;
        if (imem_addr !== 32'd0 || pc_plus4 !== 32'd4) begin
            errors++;
            $display("FAIL pc_wrap: addr=%h pc4=%h, expected 0/4", imem_addr, pc_plus4);
        end
    endtask

    task automatic test_stall();
        do_instr($urandom, 0, 5, 1'b0, 32'd0);
        do_instr($urandom, 1, 2, 1'b1, 32'h0000_0040);
    endtask

    task automatic test_misaligned();
        test_reset();
        do_instr($urandom, 0, 0, 1'b1, 32'h0000_0020);
        do_instr($urandom, 1, 0, 1'b1, 32'h0000_0006);
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'($urandom); stall = 1'($urandom); pc_src = 1'($urandom); imm_ext = $urandom;
            tick();
            checks++;
            if (fault !== 1'b1 || fault_code !== 2'b01 || pc !== 32'h0000_0026 || instret !== m_instret ||
                imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP) begin
                errors++;
                $display("FAIL fault_sticky: fault=%b code=%b pc=%h instret=%0d req=%b valid=%b, expected 1/01/00000026/%0d/0/0",
                         fault, fault_code, pc, instret, imem_req, instr_valid, m_instret);
            end
        end
        imem_ack = 1'b0; stall = 1'b0;
    endtask

    task automatic test_timeout();
        test_reset();
        for (int i = 0; i < MAXW; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd0 || fault !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait: cycle=%0d req=%b addr=%h fault=%b, expected 1/0/0", i, imem_req, imem_addr, fault);
            end
        end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10 || imem_req !== 1'b0 || pc !== 32'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL timeout: fault=%b code=%b req=%b pc=%h instret=%0d, expected 1/10/0/0/0",
                     fault, fault_code, imem_req, pc, instret);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: fault=%b code=%b valid=%b, expected 1/10/0", fault, fault_code, instr_valid);
        end
    endtask

    task automatic test_reset_mid_fetch();
        test_reset();
        do_instr($urandom, 0, 0, 1'b1, 32'h0000_0040);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (pc !== 32'd0 || instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1 || instret !== 32'd0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fetch: pc=%h valid=%b instr=%h req=%b instret=%0d fault=%b, expected 0/0/%h/1/0/0",
                     pc, instr_valid, instr, imem_req, instret, fault, NOP);
        end
        m_pc = 32'd0;
        m_instret = 32'd0;
        do_instr($urandom, 1, 0, 1'b0, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] imm;
        test_reset();
        for (int n = 0; n < 40; n++) begin
            imm = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 1) == 1) imm = 32'd0 - imm;
            do_instr($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom), imm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cold_start();
        test_delay();
        test_stall();
        test_branch();
        test_misaligned();
        test_timeout();
        test_reset_mid_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
